// File: rtl/fp_flags_tracker.sv
// FPU exception-flag tracker: buffers per-sqN flag updates, drops squashed ones,
// and ORs committed flags into the architectural fflags register.
module fp_flags_tracker #(
   parameter int SQN_W      = 7,
   parameter int DEPTH      = 32,
   parameter int NUM_COMMIT = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        IN_upd_valid,
   input  logic [SQN_W-1:0]            IN_upd_sqN,
   input  logic [4:0]                  IN_upd_flags,
   input  logic                        IN_branch_taken,
   input  logic [SQN_W-1:0]            IN_branch_sqN,
   input  logic [NUM_COMMIT-1:0]       IN_comm_valid,
   input  logic [NUM_COMMIT*SQN_W-1:0] IN_comm_sqN,
   input  logic                        IN_csr_we,
   input  logic [4:0]                  IN_csr_wdata,
   output logic [4:0]                  OUT_fflags,
   output logic                        OUT_err
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [SQN_W-1:0] sqn_q   [DEPTH];
   logic [SQN_W-1:0] sqn_d   [DEPTH];
   logic [4:0]       flags_q [DEPTH];
   logic [4:0]       flags_d [DEPTH];
   logic [4:0]       fflags_q, fflags_d;
   logic             err_q, err_d;

   logic [SQN_W-1:0] comm_sqn [NUM_COMMIT];
   logic [IDX_W-1:0] comm_idx [NUM_COMMIT];
   logic [IDX_W-1:0] upd_idx;
   logic             upd_live;
   logic             upd_blocked;
   logic [4:0]       hit_acc;

   // Wrap-safe age compare: true when a is strictly younger than b.
   function automatic logic is_younger(input logic [SQN_W-1:0] a,
                                       input logic [SQN_W-1:0] b);
      logic signed [SQN_W-1:0] diff;
      diff = $signed(a - b);
      return !diff[SQN_W-1] && (diff != '0);
   endfunction

   always_comb begin
      for (int p = 0; p < NUM_COMMIT; p++) begin
         comm_sqn[p] = IN_comm_sqN[p*SQN_W +: SQN_W];
         comm_idx[p] = comm_sqn[p][IDX_W-1:0];
      end
   end

   assign upd_idx  = IN_upd_sqN[IDX_W-1:0];
   assign upd_live = IN_upd_valid &&
                     !(IN_branch_taken && is_younger(IN_upd_sqN, IN_branch_sqN));

   always_comb begin
      valid_d     = valid_q;
      sqn_d       = sqn_q;
      flags_d     = flags_q;
      err_d       = err_q;
      hit_acc     = '0;
      upd_blocked = 1'b0;

      if (IN_branch_taken) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && is_younger(sqn_q[i], IN_branch_sqN)) begin
               valid_d[i] = 1'b0;
            end
         end
      end

      // Commit reads pre-clear state, so it wins over a same-cycle branch clear.
      for (int p = 0; p < NUM_COMMIT; p++) begin
         if (IN_comm_valid[p]) begin
            if (upd_live && (IN_upd_sqN == comm_sqn[p])) begin
               hit_acc              = hit_acc | IN_upd_flags;
               valid_d[comm_idx[p]] = 1'b0;
            end else if (valid_q[comm_idx[p]] && (sqn_q[comm_idx[p]] == comm_sqn[p])) begin
               hit_acc              = hit_acc | flags_q[comm_idx[p]];
               valid_d[comm_idx[p]] = 1'b0;
            end else begin
               err_d = 1'b1;
            end
            if (comm_idx[p] == upd_idx) begin
               upd_blocked = 1'b1;
            end
         end
      end

      if (upd_live && !upd_blocked) begin
         if (valid_q[upd_idx]) begin
            err_d = 1'b1;
         end
         valid_d[upd_idx] = 1'b1;
         sqn_d[upd_idx]   = IN_upd_sqN;
         flags_d[upd_idx] = IN_upd_flags;
      end

      if (IN_csr_we && (|IN_comm_valid)) begin
         err_d = 1'b1;
      end

      fflags_d = IN_csr_we ? IN_csr_wdata : (fflags_q | hit_acc);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q  <= '0;
         fflags_q <= '0;
         err_q    <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         fflags_q <= fflags_d;
         err_q    <= err_d;
      end
   end

   // Slot payload is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      sqn_q   <= sqn_d;
      flags_q <= flags_d;
   end

   assign OUT_fflags = fflags_q;
   assign OUT_err    = err_q;

endmodule

// File: tb/tb_fp_flags_tracker.sv
// Bench for fp_flags_tracker: sqN-keyed reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fp_flags_tracker;

   localparam int SQN_W = 7;
   localparam int DEPTH = 32;
   localparam int NC    = 2;
   localparam int NSQ   = 1 << SQN_W;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             IN_upd_valid = 1'b0;
   logic [SQN_W-1:0] IN_upd_sqN = '0;
   logic [4:0]       IN_upd_flags = '0;
   logic             IN_branch_taken = 1'b0;
   logic [SQN_W-1:0] IN_branch_sqN = '0;
   logic [NC-1:0]    IN_comm_valid = '0;
   logic [SQN_W-1:0] cs0 = '0, cs1 = '0;
   logic             IN_csr_we = 1'b0;
   logic [4:0]       IN_csr_wdata = '0;
   logic [4:0]       OUT_fflags;
   logic             OUT_err;

   fp_flags_tracker #(.SQN_W(SQN_W), .DEPTH(DEPTH), .NUM_COMMIT(NC)) dut (
      .clk(clk), .rst(rst),
      .IN_upd_valid(IN_upd_valid), .IN_upd_sqN(IN_upd_sqN), .IN_upd_flags(IN_upd_flags),
      .IN_branch_taken(IN_branch_taken), .IN_branch_sqN(IN_branch_sqN),
      .IN_comm_valid(IN_comm_valid), .IN_comm_sqN({cs1, cs0}),
      .IN_csr_we(IN_csr_we), .IN_csr_wdata(IN_csr_wdata),
      .OUT_fflags(OUT_fflags), .OUT_err(OUT_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
   endtask

   // Reference model: pending updates keyed by full sqN.
   bit         m_pend  [NSQ];
   logic [4:0] m_flags [NSQ];
   logic [4:0] m_fflags = '0;
   logic       m_err    = 1'b0;

   function automatic bit younger(input int a, input int b);
      int d;
      d = (a - b) & (NSQ - 1);
      return (d >= 1) && (d < NSQ / 2);
   endfunction

   always @(negedge rst) begin
      for (int k = 0; k < NSQ; k++) m_pend[k] = 0;
      m_fflags = '0;
      m_err    = 1'b0;
   end

   always @(posedge clk) begin
      if (rst) begin
         bit         old_pend [NSQ];
         bit         upd_ok, blocked;
         logic [4:0] acc;
         int         cs [NC];
         int         us, bs;
         logic       nerr;
         old_pend = m_pend;
         us = int'(IN_upd_sqN);
         bs = int'(IN_branch_sqN);
         cs[0] = int'(cs0);
         cs[1] = int'(cs1);
         upd_ok  = IN_upd_valid && !(IN_branch_taken && younger(us, bs));
         blocked = 0;
         acc     = '0;
         nerr    = m_err;
         if (IN_branch_taken)
            for (int k = 0; k < NSQ; k++)
               if (old_pend[k] && younger(k, bs)) m_pend[k] = 0;
         for (int p = 0; p < NC; p++) begin
            if (IN_comm_valid[p]) begin
               if (upd_ok && us == cs[p]) acc |= IN_upd_flags;
               else if (old_pend[cs[p]]) begin
                  acc |= m_flags[cs[p]];
                  m_pend[cs[p]] = 0;
               end else nerr = 1'b1;
               if ((cs[p] % DEPTH) == (us % DEPTH)) blocked = 1;
            end
         end
         if (upd_ok && !blocked) begin
            for (int k = 0; k < NSQ; k++)
               if ((k % DEPTH) == (us % DEPTH)) begin
                  if (old_pend[k]) nerr = 1'b1;
                  m_pend[k] = 0;
               end
            m_pend[us]  = 1;
            m_flags[us] = IN_upd_flags;
         end
         if (IN_csr_we && (|IN_comm_valid)) nerr = 1'b1;
         m_err    = nerr;
         m_fflags = IN_csr_we ? IN_csr_wdata : (m_fflags | acc);
      end
   end

   always @(negedge clk) begin
      chk("model_fflags", OUT_fflags, m_fflags);
      chk("model_err", {4'b0, OUT_err}, {4'b0, m_err});
   end

   task automatic idle();
      IN_upd_valid = 0; IN_upd_sqN = '0; IN_upd_flags = '0;
      IN_branch_taken = 0; IN_branch_sqN = '0;
      IN_comm_valid = '0; cs0 = '0; cs1 = '0;
      IN_csr_we = 0; IN_csr_wdata = '0;
   endtask

   task automatic clock();
      @(posedge clk); #2; idle();
   endtask

   task automatic upd(input int s, input logic [4:0] f);
      IN_upd_valid = 1; IN_upd_sqN = SQN_W'(s); IN_upd_flags = f; clock();
   endtask

   task automatic commit1(input int s);
      IN_comm_valid = 2'b01; cs0 = SQN_W'(s); clock();
   endtask

   task automatic branch(input int s);
      IN_branch_taken = 1; IN_branch_sqN = SQN_W'(s); clock();
   endtask

   task automatic csr(input logic [4:0] v);
      IN_csr_we = 1; IN_csr_wdata = v; clock();
   endtask

   task automatic do_reset();
      rst = 0; #1;
      chk("rst_fflags", OUT_fflags, 5'b00000);
      chk("rst_err", {4'b0, OUT_err}, 5'b00000);
      @(posedge clk); #2; rst = 1;
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #2 rst = 1;
      chk("reset_fflags", OUT_fflags, 5'b00000);
      chk("reset_err", {4'b0, OUT_err}, 5'b00000);

      upd(5, 5'b00001);
      commit1(5);
      chk("t1_fflags", OUT_fflags, 5'b00001);
      chk("t1_err", {4'b0, OUT_err}, 5'b00000);

      csr(5'b00000);
      upd(10, 5'b10000);
      upd(11, 5'b00100);
      IN_comm_valid = 2'b11; cs0 = 7'd10; cs1 = 7'd11; clock();
      chk("t2_dual", OUT_fflags, 5'b10100);
      chk("t2_err", {4'b0, OUT_err}, 5'b00000);

      csr(5'b00000);
      upd(127, 5'b00010);
      upd(0, 5'b00100);
      branch(127);
      commit1(127);
      chk("t4_wrap_hit", OUT_fflags, 5'b00010);
      chk("t4_err", {4'b0, OUT_err}, 5'b00000);
      commit1(0);
      chk("t4_slot0_cleared", {4'b0, OUT_err}, 5'b00001);
      chk("t4_fflags_kept", OUT_fflags, 5'b00010);

      do_reset();
      IN_upd_valid = 1; IN_upd_sqN = 7'd3; IN_upd_flags = 5'b00001;
      IN_comm_valid = 2'b01; cs0 = 7'd3; clock();
      chk("t5_bypass", OUT_fflags, 5'b00001);
      chk("t5_err", {4'b0, OUT_err}, 5'b00000);
      commit1(3);
      chk("t5_slot3_invalid", {4'b0, OUT_err}, 5'b00001);

      do_reset();
      upd(20, 5'b00010);
      upd(21, 5'b01000);
      branch(20);
      commit1(20);
      chk("t3_keep_equal", OUT_fflags, 5'b00010);
      chk("t3_err0", {4'b0, OUT_err}, 5'b00000);
      commit1(21);
      chk("t3_squashed_miss", {4'b0, OUT_err}, 5'b00001);
      chk("t3_fflags_unch", OUT_fflags, 5'b00010);

      do_reset();
      upd(8, 5'b00001);
      chk("ow_err0", {4'b0, OUT_err}, 5'b00000);
      upd(40, 5'b00010);
      chk("ow_err", {4'b0, OUT_err}, 5'b00001);
      commit1(40);
      chk("ow_new_data", OUT_fflags, 5'b00010);

      do_reset();
      csr(5'b11111);
      chk("t6_csr_set", OUT_fflags, 5'b11111);
      csr(5'b00000);
      chk("t6_csr_clr", OUT_fflags, 5'b00000);
      chk("t6_err0", {4'b0, OUT_err}, 5'b00000);
      upd(7, 5'b00100);
      IN_comm_valid = 2'b01; cs0 = 7'd7; IN_csr_we = 1; IN_csr_wdata = 5'b10001; clock();
      chk("t6_csr_wins", OUT_fflags, 5'b10001);
      chk("t6_csr_commit_err", {4'b0, OUT_err}, 5'b00001);
      upd(9, 5'b01000);
      do_reset();

      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
